// File: rtl/rrf_alloc_ctrl_pkg.sv
// Shared types and constants for the rename-register allocation controller.
// Ports: none (package). Provides RRF_NUM/RRF_SEL, count width, FSM encodings,
// tag/count typedefs and a grant-count helper.
package rrf_alloc_ctrl_pkg;

  localparam int RRF_NUM = 64;  // rename entries, power of two
  localparam int RRF_SEL = 6;   // log2(RRF_NUM)
  localparam int CNT_W   = 2;   // width of request/commit counts

  typedef enum logic [0:0] {
    ALLOC_RUN     = 1'b0,
    ALLOC_RECOVER = 1'b1
  } alloc_state_e;

  typedef logic [RRF_SEL-1:0] rrftag_t;
  typedef logic [RRF_SEL:0]   freenum_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Number of enables asserted this cycle (0..2).
  function automatic cnt_t grant_count(input logic en1, input logic en2);
    return cnt_t'({1'b0, en1}) + cnt_t'({1'b0, en2});
  endfunction

endpackage

// File: rtl/rrf_alloc_ctrl_if.sv
// Dispatch/commit <-> allocation controller bundle.
// Ports: req_num/dp_stall/com_num/flush toward the controller; grant enables,
// tags, stall, free count and both pointers back. slave = controller side.
interface rrf_alloc_ctrl_if;
  import rrf_alloc_ctrl_pkg::*;

  cnt_t     req_num_i;
  logic     dp_stall_i;
  cnt_t     com_num_i;
  logic     flush_i;

  logic     alloc_en1_o;
  rrftag_t  alloc_tag1_o;
  logic     alloc_en2_o;
  rrftag_t  alloc_tag2_o;
  logic     alloc_stall_o;
  freenum_t freenum_o;
  rrftag_t  rrfptr_o;
  rrftag_t  comptr_o;

  modport slave (
    input  req_num_i, dp_stall_i, com_num_i, flush_i,
    output alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o,
           alloc_stall_o, freenum_o, rrfptr_o, comptr_o
  );

  modport master (
    output req_num_i, dp_stall_i, com_num_i, flush_i,
    input  alloc_en1_o, alloc_tag1_o, alloc_en2_o, alloc_tag2_o,
           alloc_stall_o, freenum_o, rrfptr_o, comptr_o
  );

endinterface

// File: rtl/rrf_alloc_ctrl.sv
// Rename-register free-list allocator: circular buffer handing out up to two
// rrftags per cycle, retiring on commit, recovering the pointer on flush.
// Latency: grants/tags are combinational (0 cycles); pointers update next edge.
// Backpressure: all-or-nothing grant; alloc_stall_o when request > free count,
// dp_stall_i silently suppresses grants.
// Ports: clk_i, reset_i (async active-high), bus (rrf_alloc_ctrl_if.slave).
// Optional feature macro RRF_ALLOC_PERF_EN adds perf_stall_cnt_o and
// perf_alloc_cnt_o (32-bit wrapping counters).
module rrf_alloc_ctrl
  import rrf_alloc_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 reset_i,
`ifdef RRF_ALLOC_PERF_EN
  output logic [31:0]          perf_stall_cnt_o,
  output logic [31:0]          perf_alloc_cnt_o,
`endif
  rrf_alloc_ctrl_if.slave      bus
);

  localparam logic [RRF_SEL+1:0] FREE_MAX_W = (RRF_SEL+2)'(RRF_NUM);
  localparam freenum_t           FREE_MAX   = (RRF_SEL+1)'(RRF_NUM);

  alloc_state_e r_state;
  rrftag_t      r_rrfptr;
  rrftag_t      r_comptr;
  freenum_t     r_freenum;

  logic            w_req_over;
  logic            w_grant_ok;
  logic            w_en1;
  logic            w_en2;
  logic            w_stall;
  cnt_t            w_granted;
  rrftag_t         w_comptr_nxt;
  logic [RRF_SEL+1:0] w_free_sum;
  freenum_t        w_free_nxt;

  // Grants look only at the registered free count; same-cycle commits are
  // deliberately not forwarded so the compare stays off the commit path.
  assign w_req_over = freenum_t'(bus.req_num_i) > r_freenum;

  // Reset is folded in so the enables read 0 while reset is held, even if
  // dispatch keeps requesting.
  assign w_grant_ok = !reset_i && (r_state == ALLOC_RUN) && !bus.flush_i &&
                      !bus.dp_stall_i && !w_req_over;

  assign w_en1   = w_grant_ok && (bus.req_num_i != 2'd0);
  assign w_en2   = w_grant_ok && (bus.req_num_i == 2'd2);

  always_comb begin
    w_stall = 1'b0;
    if (!reset_i) begin
      if (r_state == ALLOC_RECOVER) w_stall = (bus.req_num_i != 2'd0);
      else                          w_stall = w_req_over;
    end
  end

  assign w_granted    = grant_count(w_en1, w_en2);
  assign w_comptr_nxt = r_comptr + rrftag_t'(bus.com_num_i);

  // Over-commit would push the count past the file size; clamp so the counter
  // never reports more free entries than exist.
  assign w_free_sum = {1'b0, r_freenum} + (RRF_SEL+2)'(bus.com_num_i)
                      - (RRF_SEL+2)'(w_granted);
  assign w_free_nxt = (w_free_sum > FREE_MAX_W) ? FREE_MAX
                                                : w_free_sum[RRF_SEL:0];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ALLOC_RUN;
      r_rrfptr  <= '0;
      r_comptr  <= '0;
      r_freenum <= FREE_MAX;
    end else if (bus.flush_i) begin
      // Everything younger than commit is squashed: allocation restarts just
      // past the last committed entry and the whole file becomes free.
      r_state   <= ALLOC_RECOVER;
      r_rrfptr  <= w_comptr_nxt;
      r_comptr  <= w_comptr_nxt;
      r_freenum <= FREE_MAX;
    end else begin
      r_state   <= ALLOC_RUN;
      r_rrfptr  <= r_rrfptr + rrftag_t'(w_granted);
      r_comptr  <= w_comptr_nxt;
      r_freenum <= w_free_nxt;
    end
  end

  assign bus.alloc_en1_o   = w_en1;
  assign bus.alloc_en2_o   = w_en2;
  assign bus.alloc_tag1_o  = r_rrfptr;
  assign bus.alloc_tag2_o  = r_rrfptr + rrftag_t'(1);
  assign bus.alloc_stall_o = w_stall;
  assign bus.freenum_o     = r_freenum;
  assign bus.rrfptr_o      = r_rrfptr;
  assign bus.comptr_o      = r_comptr;

`ifdef RRF_ALLOC_PERF_EN
  logic [31:0] r_perf_stall_cnt;
  logic [31:0] r_perf_alloc_cnt;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_perf_stall_cnt <= '0;
      r_perf_alloc_cnt <= '0;
    end else begin
      r_perf_stall_cnt <= r_perf_stall_cnt + 32'(w_stall);
      r_perf_alloc_cnt <= r_perf_alloc_cnt + 32'(w_granted);
    end
  end

  assign perf_stall_cnt_o = r_perf_stall_cnt;
  assign perf_alloc_cnt_o = r_perf_alloc_cnt;
`endif

endmodule

// File: doc/rrf_alloc_ctrl.md
# rrf_alloc_ctrl

Rename-register allocation controller: tracks the free list of the rename register file as a circular buffer and hands out up to two destination rrftags per cycle to dispatch. Retires entries as the commit stage completes instructions, and recovers the allocation pointer on a pipeline flush. Sits between decode/dispatch and the rename register file, driving its allocate ports and stalling dispatch when the file is exhausted.

## Interface
- `RRF_NUM`, 64: number of rename entries. Must be a power of two.
- `RRF_SEL`, 6: tag width, equal to log2(`RRF_NUM`).
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous active-high reset.
- `req_num_i`  in  2  tags requested by dispatch this cycle (0, 1 or 2; 3 is illegal).
- `dp_stall_i`  in  1  downstream stall. Forces zero grants.
- `com_num_i`  in  2  entries retired by commit this cycle (0–2).
- `flush_i`  in  1  mispredict/exception flush.
- `alloc_en1_o`  out  1  first tag granted.
- `alloc_tag1_o`  out  `RRF_SEL`  first tag.
- `alloc_en2_o`  out  1  second tag granted.
- `alloc_tag2_o`  out  `RRF_SEL`  second tag.
- `alloc_stall_o`  out  1  request cannot be served.
- `freenum_o`  out  `RRF_SEL`+1  free entries.
- `rrfptr_o`  out  `RRF_SEL`  next tag to allocate.
- `comptr_o`  out  `RRF_SEL`  oldest uncommitted tag.

## Operation
- State:
  - `rrfptr`, `comptr`: registered, reset 0.
  - `freenum`: registered, reset `RRF_NUM`.
  - FSM state: RUN or RECOVER, reset RUN.
- Tags are combinational from registered `rrfptr`:
  - `alloc_tag1_o` = `rrfptr`.
  - `alloc_tag2_o` = `rrfptr`+1 mod `RRF_NUM`. Wrap is natural truncation.
- Grant rule in RUN: all-or-nothing.
  - If `req_num_i` > `freenum`: assert `alloc_stall_o`, grant nothing.
  - Else: `alloc_en1_o` = (`req_num_i`≥1), `alloc_en2_o` = (`req_num_i`==2), provided `dp_stall_i`=0 and `flush_i`=0.
  - `dp_stall_i` suppresses grants but does not assert `alloc_stall_o`.
- Same-cycle commit frees are not visible to the grant. Grants use the current registered `freenum`.
- Update on each edge, with `granted` = number of enables asserted:
  - `rrfptr` += `granted`.
  - `comptr` += `com_num_i`.
  - `freenum` += `com_num_i` − `granted`.
- Precondition: `com_num_i` ≤ `RRF_NUM` − `freenum`. A violation is a checker error; the RTL clamps `freenum` at `RRF_NUM`.
- Flush (priority over allocation):
  - Grants are suppressed in the flush cycle.
  - Next state: `rrfptr` = `comptr` + `com_num_i`, `comptr` = `comptr` + `com_num_i`, `freenum` = `RRF_NUM`, state RECOVER.
- RECOVER:
  - Lasts exactly one cycle.
  - No grants. `alloc_stall_o` = 1 if `req_num_i` ≠ 0.
  - Commits are still accepted.
  - Returns to RUN.
- A flush during RECOVER re-applies the flush and stays in RECOVER one more cycle.
- Full: `freenum`=0 → any request stalls.
- Empty: `freenum`=`RRF_NUM`, `rrfptr`==`comptr`.

## Timing
- Grant latency 0: enables and tags are valid in the cycle of the request.
- Pointer and counter updates are visible on the next edge.
- Reset values of outputs:
  - All enables 0, `alloc_stall_o` 0.
  - `alloc_tag1_o`=0, `alloc_tag2_o`=1.
  - `freenum_o`=`RRF_NUM`, `rrfptr_o`=0, `comptr_o`=0.
- Reset asserted mid-operation clears all state immediately (asynchronous). Outputs reach reset values without a clock edge.
- Reset deassertion is synchronised externally. The first grant is possible in the first clock after release.

## Configuration
- `RRF_ALLOC_PERF_EN` defined adds two outputs:
  - `perf_stall_cnt_o` (32): increments each cycle `alloc_stall_o`=1.
  - `perf_alloc_cnt_o` (32): adds `granted` each cycle.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- `RRF_NUM` and `RRF_SEL` come from `consts/Consts.vh`.
- Add to `consts/Consts.vh`: FSM state encodings (`ALLOC_RUN`=0, `ALLOC_RECOVER`=1) and the 2-bit request/commit count width.
- Single module; no sub-module. The perf counters are an inline `ifdef` block.

## Test plan
- Reset: `freenum_o`=64, tags 0/1, `alloc_stall_o`=0, all enables 0.
- `req_num_i`=2 for 32 cycles → tags 0..63 granted in order, `freenum_o`=0. Then `req_num_i`=1 → `alloc_stall_o`=1, no enables.
- Wrap: `rrfptr`=63, `freenum`=4, `req_num_i`=2 → tags 63 and 0, next `rrfptr_o`=1, `freenum_o`=2.
- Simultaneous: `freenum`=1, `req_num_i`=2, `com_num_i`=2 → stall this cycle. Next cycle `freenum_o`=3 and the request is granted.
- Flush: `comptr`=10, `com_num_i`=1, `flush_i`=1 → next `rrfptr_o`=11, `comptr_o`=11, `freenum_o`=64. The following cycle `req_num_i`=1 → `alloc_stall_o`=1 (RECOVER). The cycle after → tag 11 granted.
- Async reset asserted mid-allocation burst (`rrfptr`=20) → outputs return to reset values before the next edge. After release, the first grant is tag 0.
